mp_adder_seq: RTL

Multi-precision add/subtract sequencer built around a single 8-bit registered ripple slice with carry feedback. It accepts two WORDS-byte operands over a valid/ready handshake and steps the 8-bit slice once per byte, least-significant first, chaining the carry between bytes. It returns the full-width result and carry-out over a second valid/ready handshake. It sits between the datapath issue logic and the shared 8-bit adder resource, which lets wide arithmetic reuse the narrow sequential adder.

---
 rtl/mp_adder_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: multi-precision add/subtract built on one 8-bit slice with carry feedback.
// Operands are consumed one byte per cycle, least-significant first.
module mp_adder_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   out_sum,
    output logic                 out_carry,
    output logic                 busy
);

    localparam int unsigned W  = 8 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   sum_r;
    logic           carry_r;
    logic [IW-1:0]  idx;

    logic [7:0]     a_byte_c;
    logic [7:0]     b_byte_c;
    logic [8:0]     slice_c;
    logic [IW+2:0]  shift_c;

    // Byte select and the 8-bit slice: two bytes plus the chained carry.
    always_comb begin
        shift_c  = {idx, 3'b000};
        a_byte_c = 8'(a_r >> shift_c);
        b_byte_c = 8'(b_r >> shift_c);
        slice_c  = 9'(a_byte_c) + 9'(b_byte_c) + 9'(carry_r);
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Subtract is A + ~B + 1: invert B and seed the carry.
                        a_r      <= in_a;
                        b_r      <= in_sub ? ~in_b : in_b;
                        carry_r  <= in_sub;
                        sum_r    <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // sum_r was cleared on accept, so OR-ing in the byte is a write.
                    sum_r   <= sum_r | (W'(slice_c[7:0]) << shift_c);
                    carry_r <= slice_c[8];
                    idx     <= idx + IW'(1);
                    if (idx == IW'(WORDS - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum   = sum_r;
    assign out_carry = carry_r;

endmodule
